// File: rtl/password_store_arbiter.sv
// password_store_arbiter
//   Single-port access controller for the 4-entry password store. Arbitrates
//   between the password setter (write requester) and the password validator
//   (read requester) round-robin, and sequences a bulk clear that overwrites
//   every entry with CLEAR_VALUE.
//
// Ports
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   wrReq/wrAddr/wrData      write request, held until wrGrant
//   wrGrant                  write happens at the end of this cycle
//   rdReq/rdAddr             read request, held until rdGrant
//   rdGrant                  rdAddr is on the store address this cycle
//   rdValid/rdData           read data, one cycle after rdGrant
//   clrReq                   start a clear sequence (sampled in S_IDLE only)
//   clrBusy                  clear sequence in progress (state is S_CLEAR)
//   clrDone                  pulse on the final clear write
//   memAddress/memShouldWrite/memInputData/memOutputData  store pins
//   dbgState                 current state encoding
module password_store_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wrReq,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  wrGrant,
  input  logic                  rdReq,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  rdGrant,
  output logic                  rdValid,
  output logic [DATA_WIDTH-1:0] rdData,
  input  logic                  clrReq,
  output logic                  clrBusy,
  output logic                  clrDone,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memShouldWrite,
  output logic [DATA_WIDTH-1:0] memInputData,
  input  logic [DATA_WIDTH-1:0] memOutputData,
  output logic [1:0]            dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clrCount_q, clrCount_d;
  logic                    lastGrant_q, lastGrant_d;  // 0 = read, 1 = write
  logic                    rdValid_q;

  logic                    wr_gnt, rd_gnt, clr_done, mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wd;

  always_comb begin
    state_d     = state_q;
    clrCount_d  = clrCount_q;
    lastGrant_d = lastGrant_q;
    wr_gnt      = 1'b0;
    rd_gnt      = 1'b0;
    clr_done    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wd      = '0;
    case (state_q)
      S_IDLE: begin
        if (clrReq) begin
          // The first clear write (address 0) happens in this cycle, so the
          // sequence occupies exactly DEPTH cycles.
          mem_we = 1'b1;
          mem_wd = CLEAR_VALUE;
          if (DEPTH == 1) begin
            clr_done   = 1'b1;
            clrCount_d = '0;
          end else begin
            clrCount_d = ADDR_WIDTH'(1);
            state_d    = S_CLEAR;
          end
        end else if (wrReq && (!rdReq || !lastGrant_q)) begin
          // On a tie the write wins only if the read was granted last.
          wr_gnt      = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = wrAddr;
          mem_wd      = wrData;
          lastGrant_d = 1'b1;
        end else if (rdReq) begin
          rd_gnt      = 1'b1;
          mem_addr    = rdAddr;
          lastGrant_d = 1'b0;
        end
      end
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clrCount_q;
        mem_wd   = CLEAR_VALUE;
        if (clrCount_q == LAST_ADDR) begin
          clr_done   = 1'b1;
          clrCount_d = '0;
          state_d    = S_IDLE;
        end else begin
          clrCount_d = clrCount_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        clrCount_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      clrCount_q  <= '0;
      lastGrant_q <= 1'b1;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCount_q  <= clrCount_d;
      lastGrant_q <= lastGrant_d;
      rdValid_q   <= rd_gnt;
    end
  end

  // Outputs are forced quiet while reset is held; the state register alone
  // would still let a pending request be granted during reset.
  assign wrGrant        = wr_gnt & ~RST;
  assign rdGrant        = rd_gnt & ~RST;
  assign clrDone        = clr_done & ~RST;
  assign memShouldWrite = mem_we & ~RST;
  assign memAddress     = mem_addr;
  assign memInputData   = mem_wd;
  assign clrBusy        = (state_q == S_CLEAR) & ~RST;
  assign rdValid        = rdValid_q;
  assign rdData         = memOutputData;
  assign dbgState       = state_q;

endmodule

// File: tb/tb_password_store_arbiter.sv
module tb_password_store_arbiter;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wrReq, rdReq, clrReq;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [DW-1:0] wrData;
  logic          wrGrant, rdGrant, rdValid, clrBusy, clrDone, memShouldWrite;
  logic [DW-1:0] rdData, memInputData, memOutputData;
  logic [AW-1:0] memAddress;
  logic [1:0]    dbgState;

  password_store_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CLEAR_VALUE('0)
  ) dut (
    .CLK(CLK), .RST(RST),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGrant(wrGrant),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdGrant(rdGrant), .rdValid(rdValid),
    .rdData(rdData), .clrReq(clrReq), .clrBusy(clrBusy), .clrDone(clrDone),
    .memAddress(memAddress), .memShouldWrite(memShouldWrite),
    .memInputData(memInputData), .memOutputData(memOutputData),
    .dbgState(dbgState)
  );

  always #5 CLK = ~CLK;

  // Behavioural store: synchronous write, registered read.
  logic [DW-1:0] store_mem [DEPTH];
  always @(posedge CLK) begin
    if (memShouldWrite) store_mem[memAddress] <= memInputData;
    memOutputData <= store_mem[memAddress];
  end

  // Reference model state: contents the store should hold, and who was
  // granted last (1 = write), plus the queue of expected read data.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            last_model;
  logic [DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  bit prev_rg = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: read data and read timing, single-grant rule.
  always @(negedge CLK) begin
    if (RST) begin
      prev_rg = 1'b0;
    end else begin
      chk("rdValid_timing", 32'(rdValid), 32'(prev_rg));
      chk("one_grant", 32'(wrGrant & rdGrant), 32'd0);
      if (rdValid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rdData", 32'(rdData), 32'(exp_q.pop_front()));
      end
      prev_rg = rdGrant;
    end
  end

  // Issue a write and/or read request and check the grant each cycle against
  // the round-robin rule. Called and returns at posedge+1.
  task automatic service(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit re, input logic [AW-1:0] ra);
    bit wp, rp, ew, er;
    wp = we; rp = re;
    wrReq = we; wrAddr = wa; wrData = wd;
    rdReq = re; rdAddr = ra;
    for (int c = 0; c < 2 && (wp || rp); c++) begin
      @(negedge CLK);
      ew = wp && (!rp || !last_model);
      er = rp && !ew;
      chk("wrGrant", 32'(wrGrant), 32'(ew));
      chk("rdGrant", 32'(rdGrant), 32'(er));
      if (ew) begin ref_mem[wa] = wd; wp = 1'b0; last_model = 1'b1; end
      if (er) begin exp_q.push_back(ref_mem[ra]); rp = 1'b0; last_model = 1'b0; end
      @(posedge CLK); #1;
      wrReq = wp; rdReq = rp;
    end
    wrReq = 1'b0; rdReq = 1'b0;
  endtask

  // Clear sequence, optionally with a simultaneous write request, optionally
  // with reset asserted on clear cycle rst_at.
  task automatic do_clear(input bit with_wr, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input int rst_at);
    clrReq = 1'b1;
    if (with_wr) begin wrReq = 1'b1; wrAddr = wa; wrData = wd; end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == rst_at) begin
        RST = 1'b1;
        #1;
        chk("rst_dbgState", 32'(dbgState), 32'd0);
        chk("rst_clrBusy", 32'(clrBusy), 32'd0);
        chk("rst_memWrite", 32'(memShouldWrite), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        clrReq = 1'b0; wrReq = 1'b0;
        last_model = 1'b1;
        exp_q.delete();
        return;
      end
      @(negedge CLK);
      chk("clr_busy", 32'(clrBusy), 32'(i != 0));
      chk("clr_dbgState", 32'(dbgState), 32'(i != 0));
      chk("clr_we", 32'(memShouldWrite), 32'd1);
      chk("clr_addr", 32'(memAddress), 32'(i));
      chk("clr_data", 32'(memInputData), 32'd0);
      chk("clr_nogrant", 32'({wrGrant, rdGrant}), 32'd0);
      chk("clr_done", 32'(clrDone), 32'(i == DEPTH - 1));
      ref_mem[i] = '0;
      @(posedge CLK); #1;
      clrReq = 1'b0;
    end
    if (with_wr) begin
      @(negedge CLK);
      chk("post_clr_wrGrant", 32'(wrGrant), 32'd1);
      ref_mem[wa] = wd;
      last_model = 1'b1;
      @(posedge CLK); #1;
      wrReq = 1'b0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wrReq = 1'b1; rdReq = 1'b1; wrAddr = '0; rdAddr = '0; wrData = 4'd5;
    @(negedge CLK);
    chk("reset_wrGrant", 32'(wrGrant), 32'd0);
    chk("reset_rdGrant", 32'(rdGrant), 32'd0);
    chk("reset_rdValid", 32'(rdValid), 32'd0);
    chk("reset_clrBusy", 32'(clrBusy), 32'd0);
    chk("reset_clrDone", 32'(clrDone), 32'd0);
    chk("reset_memWrite", 32'(memShouldWrite), 32'd0);
    chk("reset_dbgState", 32'(dbgState), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    wrReq = 1'b0; rdReq = 1'b0;
    last_model = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_model = 1'b1;
    clrReq = 1'b0; wrReq = 1'b0; rdReq = 1'b0;
    wrAddr = '0; rdAddr = '0; wrData = '0;
    RST = 1'b1;
    @(posedge CLK); #1;
    do_reset();

    // Write then read back.
    service(1'b1, 2'd2, 4'd7, 1'b0, 2'd0);
    service(1'b0, 2'd0, 4'd0, 1'b1, 2'd2);
    @(posedge CLK); #1;

    // Tie after reset: read, write, read, write.
    do_reset();
    service(1'b1, 2'd3, 4'd4, 1'b1, 2'd2);
    service(1'b1, 2'd0, 4'd8, 1'b1, 2'd2);

    // Load 3,5,9,1 then clear, read back.
    service(1'b1, 2'd0, 4'd3, 1'b0, 2'd0);
    service(1'b1, 2'd1, 4'd5, 1'b0, 2'd0);
    service(1'b1, 2'd2, 4'd9, 1'b0, 2'd0);
    service(1'b1, 2'd3, 4'd1, 1'b0, 2'd0);
    do_clear(1'b0, 2'd0, 4'd0, -1);
    for (int a = 0; a < DEPTH; a++) service(1'b0, 2'd0, 4'd0, 1'b1, AW'(a));

    // Clear together with a write: write lands after clrDone.
    do_clear(1'b1, 2'd1, 4'd6, -1);
    service(1'b0, 2'd0, 4'd0, 1'b1, 2'd1);

    // Reset on the second clear cycle.
    service(1'b1, 2'd0, 4'd3, 1'b0, 2'd0);
    service(1'b1, 2'd1, 4'd5, 1'b0, 2'd0);
    service(1'b1, 2'd2, 4'd9, 1'b0, 2'd0);
    service(1'b1, 2'd3, 4'd1, 1'b0, 2'd0);
    @(posedge CLK); #1;
    do_clear(1'b0, 2'd0, 4'd0, 1);
    for (int a = 0; a < DEPTH; a++) service(1'b0, 2'd0, 4'd0, 1'b1, AW'(a));

    // Read held for three back-to-back cycles.
    for (int k = 0; k < 3; k++) service(1'b0, 2'd0, 4'd0, 1'b1, 2'd3);

    // Randomized traffic.
    repeat (120) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)
        do_clear(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), -1);
      else if (kind <= 3)
        service(1'b1, AW'($urandom), DW'($urandom), 1'b0, 2'd0);
      else if (kind <= 6)
        service(1'b0, 2'd0, 4'd0, 1'b1, AW'($urandom));
      else
        service(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/password_store_arbiter.md
# password_store_arbiter

Single-port access controller for the 4-entry password store. It shares the store between the password setter (write requester) and the password validator (read requester) with round-robin arbitration. It also sequences a bulk clear that overwrites every entry with a fixed value. It sits between the store and its two requesters and owns the store's address, write-enable and write-data pins.

## Interface

- ADDR_WIDTH, 2, store address width.
- DATA_WIDTH, 4, store word width (one password digit).
- DEPTH, 4, number of store entries; must equal 2**ADDR_WIDTH.
- CLEAR_VALUE, 0, word written to every entry by a clear sequence.

- CLK  in  1  sole clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- wrReq  in  1  setter requests a write; held with wrAddr/wrData stable until wrGrant.
- wrAddr  in  ADDR_WIDTH  write address.
- wrData  in  DATA_WIDTH  write data.
- wrGrant  out  1  write is performed at the end of this cycle.
- rdReq  in  1  validator requests a read; held with rdAddr stable until rdGrant.
- rdAddr  in  ADDR_WIDTH  read address.
- rdGrant  out  1  rdAddr is presented to the store this cycle.
- rdValid  out  1  rdData is valid; asserted exactly one cycle after rdGrant.
- rdData  out  DATA_WIDTH  read data, a direct pass-through of memOutputData.
- clrReq  in  1  start a clear sequence (level; sampled only in S_IDLE).
- clrBusy  out  1  a clear sequence is in progress (state is S_CLEAR).
- clrDone  out  1  single-cycle pulse on the final clear write.
- memAddress  out  ADDR_WIDTH  store address.
- memShouldWrite  out  1  store write enable.
- memInputData  out  DATA_WIDTH  store write data.
- memOutputData  in  DATA_WIDTH  store read data, registered; valid the cycle after the address.
- dbgState  out  2  current state encoding (S_IDLE=0, S_CLEAR=1).

## Operation

- State machine with two states, S_IDLE and S_CLEAR. Registers: state, clrCount (ADDR_WIDTH bits), lastGrant (0=read, 1=write), rdValid.
- S_IDLE, priority order:
  - clrReq=1: no wr/rd grant this cycle. Drive memAddress=0, memShouldWrite=1, memInputData=CLEAR_VALUE. Set clrCount to 1. Next state is S_CLEAR, or S_IDLE if DEPTH==1 (in which case clrDone pulses this cycle).
  - Otherwise, if exactly one of wrReq/rdReq is high, grant it.
  - If both are high, grant the requester that was not last granted (round-robin), then update lastGrant.
  - Write grant: memAddress=wrAddr, memShouldWrite=1, memInputData=wrData, wrGrant=1.
  - Read grant: memAddress=rdAddr, memShouldWrite=0, rdGrant=1.
  - No grant: memShouldWrite=0, memAddress=0, memInputData=0.
- S_CLEAR:
  - Each cycle writes CLEAR_VALUE to address clrCount, then increments clrCount.
  - When clrCount==DEPTH-1: pulse clrDone, clear clrCount to 0 (wrap), and return to S_IDLE.
  - wrGrant and rdGrant are 0 throughout; requests stay pending and are not lost.
  - clrReq is ignored in this state.
- The clear sequence occupies exactly DEPTH consecutive cycles, addresses 0..DEPTH-1 in order.
- rdValid is a register loaded with rdGrant every cycle. It is independent of state, so a read granted on the cycle before a clear starts still returns valid data.
- At most one grant is asserted per cycle. wrGrant and rdGrant are never both high.

## Timing

- Reset values: state=S_IDLE, clrCount=0, lastGrant=1 (the first tie goes to read), rdValid=0.
- During reset all grants, clrBusy, clrDone and memShouldWrite are 0.
- Grants, memory outputs and clrDone are combinational from the current state and requests. clrBusy is decoded from the state register.
- Write latency: data is in the store at the rising edge that ends the wrGrant cycle.
- Read latency: rdData/rdValid are valid one cycle after rdGrant.
- Back-to-back grants are allowed every cycle. A requester that keeps its request high after a grant is treated as making a new request.
- Simultaneous clrReq, wrReq and rdReq in S_IDLE: the clear wins, and neither grant is issued until the cycle after clrDone.
- Reset asserted mid-clear: return immediately to S_IDLE with clrCount=0. Entries already cleared stay cleared, the rest keep their old contents, and the sequence is not resumed.
- Reset between rdGrant and rdValid: rdValid=0 and the read is lost.

## Test plan

- Reset, then write wrAddr=2/wrData=7: wrGrant=1 the same cycle. A following read of rdAddr=2 gives rdGrant, then rdValid=1 with rdData=7 one cycle later.
- Hold wrReq and rdReq both high for 4 cycles after reset: grant order is read, write, read, write.
- Load 3,5,9,1 into addresses 0..3, then pulse clrReq: writes to addresses 0,1,2,3 on 4 consecutive cycles, clrBusy=1 for cycles 2..4, clrDone on cycle 4. Reading all entries afterwards returns 0.
- Assert clrReq together with wrReq (addr 1, data 6): the clear runs first and wrGrant arrives the cycle after clrDone. Entry 1 then reads 6.
- Assert RST on the second clear cycle after loading 3,5,9,1: dbgState=0 immediately. Reads return 0,5,9,1.
- Single rdReq held for 3 cycles: rdGrant on each cycle and rdValid on cycles 2..4. wrGrant is never asserted.
